// File: rtl/fir_output_stage.sv
// fir_output_stage: round/scale/saturate DA sums into 16-bit samples behind a valid/ready FIFO.
// Define FIR_OUT_ROUND_EN to round half up before the shift; otherwise the result is truncated.
module fir_output_stage #(
  parameter int SHIFT = 15,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk3,
  input  logic             areset_n,
  input  logic [31:0]      sum_in,
  input  logic             sum_valid,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat_flag,
  output logic [CNT_W-1:0] drop_count,
  input  logic             clr_status
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
`ifdef FIR_OUT_ROUND_EN
  localparam logic signed [33:0] RND = 34'sd1 <<< (SHIFT-1);
`else
  localparam logic signed [33:0] RND = '0;
`endif
  logic signed [33:0] s1_data, s2_shift;
  logic               s1_valid, s2_valid, s2_sat;
  logic [15:0]        s2_data;
  logic [15:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        occ;
  logic               rd, wr, drop, sat_hi, sat_lo;
  assign s2_shift  = s1_data >>> SHIFT;
  assign sat_hi    = s2_shift > 34'sd32767;
  assign sat_lo    = s2_shift < -34'sd32768;
  assign out_valid = occ != '0;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign rd        = out_valid & out_ready;
  // a full FIFO still accepts a write when the head is popped on the same edge
  assign wr        = s2_valid & ((occ != FULL) | rd);
  assign drop      = s2_valid & ~wr;
  always_ff @(posedge clk3 or negedge areset_n)
    if (!areset_n) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s2_valid   <= 1'b0;
      s2_data    <= '0;
      s2_sat     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      sat_flag   <= 1'b0;
      drop_count <= '0;
    end else begin
      s1_valid <= sum_valid;
      if (sum_valid) s1_data <= $signed({{2{sum_in[31]}}, sum_in}) + RND;
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= sat_hi ? 16'h7fff : sat_lo ? 16'h8000 : s2_shift[15:0];
        s2_sat  <= sat_hi | sat_lo;
      end
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      occ      <= occ + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
      sat_flag <= (s2_valid & s2_sat) | (sat_flag & ~clr_status);
      drop_count <= drop ? (clr_status ? CNT_W'(1) : (&drop_count) ? drop_count : drop_count + CNT_W'(1))
                         : clr_status ? '0 : drop_count;
    end
  always_ff @(posedge clk3)
    if (wr) mem[wr_ptr] <= s2_data;
endmodule

// File: tb/tb_fir_output_stage.sv
// tb_fir_output_stage: directed vectors with a scoreboard queue checked by an output monitor.
module tb_fir_output_stage;
  logic        clk3 = 1'b0;
  logic        areset_n = 1'b0;
  logic [31:0] sum_in = '0;
  logic        sum_valid = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sat_flag;
  logic [7:0]  drop_count;
  logic        clr_status = 1'b0;
  logic [15:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  fir_output_stage #(.SHIFT(15), .DEPTH(4), .CNT_W(8)) dut (
    .clk3(clk3), .areset_n(areset_n), .sum_in(sum_in), .sum_valid(sum_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sat_flag(sat_flag), .drop_count(drop_count), .clr_status(clr_status)
  );
  always #5 clk3 = ~clk3;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk3);
    #1;
  endtask
  task automatic send(input logic [31:0] v);
    sum_in = v;
    sum_valid = 1'b1;
    tick(1);
    sum_valid = 1'b0;
  endtask
  always @(negedge clk3)
    if (areset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop got %h expected none", out_data);
      end else check("pop", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
    end
  initial begin
    #22 areset_n = 1'b1;
    tick(1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_drop", drop_count, 0);
    out_ready = 1'b1;
`ifdef FIR_OUT_ROUND_EN
    exp_q.push_back(16'h0002);
`else
    exp_q.push_back(16'h0001);
`endif
    send(32'h0000C000);
    check("lat_e0", out_valid, 0);
    tick(1);
    check("lat_e1", out_valid, 0);
    tick(1);
    check("lat_e2", out_valid, 1);
    tick(1);
    check("lat_e3", out_valid, 0);
    exp_q.push_back(16'h7fff);
    exp_q.push_back(16'h8000);
    send(32'h7FFFFFFF);
    send(32'h80000000);
    tick(4);
    check("sat_set", sat_flag, 1);
    check("sat_drained", out_valid, 0);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    check("sat_clr", sat_flag, 0);
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) exp_q.push_back(16'(2 * i));
    for (int i = 1; i <= 5; i++) send(32'(i) << 16);
    tick(4);
    check("drop_one", drop_count, 1);
    check("full_valid", out_valid, 1);
    check("hold_data", out_data, 16'h0002);
    tick(2);
    check("hold_data2", out_data, 16'h0002);
    out_ready = 1'b1;
    tick(4);
    check("drain_empty", out_valid, 0);
    out_ready = 1'b0;
    for (int i = 5; i <= 9; i++) exp_q.push_back(16'(2 * i));
    for (int i = 5; i <= 8; i++) send(32'(i) << 16);
    tick(3);
    check("full_occ", dut.occ, 4);
    send(32'h00090000);
    tick(1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("simul_occ", dut.occ, 4);
    check("simul_drop", drop_count, 1);
    check("simul_head", out_data, 16'd12);
    send(32'h000A0000);
    tick(3);
    check("drop_two", drop_count, 2);
    send(32'h000B0000);
    tick(1);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    check("clr_vs_drop", drop_count, 1);
    out_ready = 1'b1;
    tick(5);
    check("drain2_empty", out_valid, 0);
    out_ready = 1'b0;
    send(32'h00010000);
    send(32'h00020000);
    tick(1);
    send(32'h00030000);
    check("pre_rst_valid", out_valid, 1);
    #2 areset_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_drop", drop_count, 0);
    #10 areset_n = 1'b1;
    tick(4);
    check("no_stale", out_valid, 0);
    out_ready = 1'b1;
    exp_q.push_back(16'h0002);
    send(32'h00010000);
    tick(1);
    check("post_e1", out_valid, 0);
    tick(1);
    check("post_e2", out_valid, 1);
    tick(2);
    check("post_empty", out_valid, 0);
    check("q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
